// File: rtl/xport_hub_pkg.sv
// Shared constants for the cartridge peripheral hub: register offsets, bus width, synchroniser depth.
package xport_hub_pkg;
    localparam int DATA_W     = 16;
    localparam int SYNC_DEPTH = 2;

    localparam logic [3:0] OFS_LEDEN   = 4'd0;
    localparam logic [3:0] OFS_PEND    = 4'd1;
    localparam logic [3:0] OFS_MASK    = 4'd2;
    localparam logic [3:0] OFS_MODE    = 4'd3;
    localparam logic [3:0] OFS_DUTY0   = 4'd4;
    localparam logic [3:0] OFS_VERSION = 4'd15;

    // True when offset a addresses DUTY[idx] and idx is a built channel.
    function automatic logic is_duty_ofs(input logic [3:0] a, input int idx, input int num_led);
        return (idx < num_led) && (int'(a) == int'(OFS_DUTY0) + idx);
    endfunction
endpackage

// File: rtl/xport_hub_pwm_chan.sv
// One PWM LED channel: compares the shared counter with its duty and drives an active-low LED.
// Output is registered, so it follows counter/duty/enable changes one Clk later.
module xport_hub_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                Clk,
    input  logic                ResetN,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                enable,
    output logic                led_n
);
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            led_n <= 1'b1;
        end else begin
            // All-ones duty is pinned on so full brightness has no one-step gap.
            led_n <= ~(enable && ((&duty) || (cnt < duty)));
        end
    end
endmodule

// File: rtl/xport_periph_hub.sv
// Cartridge-bus peripheral hub: PWM-dimmed LEDs plus an edge-triggered interrupt controller.
// Optional level-sensitive IRQ sources are built when XPORT_HUB_IRQ_LEVEL_EN is defined.
module xport_periph_hub
    import xport_hub_pkg::*;
#(
    parameter int          NUM_LED  = 2,
    parameter int          PWM_BITS = 8,
    parameter int          PRESCALE = 16,
    parameter int          NUM_IRQ  = 4,
    parameter logic [15:0] VERSION  = 16'h0201
) (
    input  logic               Clk,
    input  logic               ResetN,
    input  logic               En,
    input  logic [3:0]         Addr,
    input  logic [15:0]        DataWr,
    output logic [15:0]        DataRd,
    input  logic               Rd,
    input  logic               Wr,
    input  logic [NUM_IRQ-1:0] IrqIn,
    output logic [NUM_LED-1:0] LedN,
    output logic               CartIReq
);
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SYNC_DEPTH-1:0] wr_sync;
    logic [SYNC_DEPTH-1:0] wr_vld;
    logic                  wr_prev;
    logic                  wr_armed;
    logic                  commit;

    logic [SYNC_DEPTH-1:0][NUM_IRQ-1:0] irq_sync;
    logic [NUM_IRQ-1:0]    irq_prev;
    logic [NUM_IRQ-1:0]    irq_set;
    logic [NUM_IRQ-1:0]    pend_clr;

    logic [NUM_LED-1:0]    leden;
    logic [NUM_IRQ-1:0]    pend;
    logic [NUM_IRQ-1:0]    mask;
    logic [PWM_BITS-1:0]   duty [NUM_LED];
    logic [PSC_W-1:0]      psc;
    logic [PWM_BITS-1:0]   cnt;
`ifdef XPORT_HUB_IRQ_LEVEL_EN
    logic [NUM_IRQ-1:0]    mode;
`endif

    logic unused_bits;
    assign unused_bits = ^{Rd, DataWr};

    // Wr is only armed once the synchroniser has seen it low after reset, so a
    // strobe that was in flight when reset hit can never commit on release.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            wr_sync  <= '0;
            wr_vld   <= '0;
            wr_prev  <= 1'b0;
            wr_armed <= 1'b0;
        end else begin
            wr_sync <= {wr_sync[SYNC_DEPTH-2:0], Wr};
            wr_vld  <= {wr_vld[SYNC_DEPTH-2:0], 1'b1};
            wr_prev <= wr_sync[SYNC_DEPTH-1];
            if (wr_vld[SYNC_DEPTH-1] && !wr_sync[SYNC_DEPTH-1]) begin
                wr_armed <= 1'b1;
            end
        end
    end

    assign commit = wr_sync[SYNC_DEPTH-1] & ~wr_prev & wr_armed & En;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            irq_sync <= '0;
            irq_prev <= '0;
        end else begin
            irq_sync <= {irq_sync[SYNC_DEPTH-2:0], IrqIn};
            irq_prev <= irq_sync[SYNC_DEPTH-1];
        end
    end

    always_comb begin
        irq_set = irq_sync[SYNC_DEPTH-1] & ~irq_prev;
`ifdef XPORT_HUB_IRQ_LEVEL_EN
        irq_set = irq_set | (mode & irq_sync[SYNC_DEPTH-1]);
`endif
        pend_clr = (commit && (Addr == OFS_PEND)) ? DataWr[NUM_IRQ-1:0] : '0;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            leden    <= '0;
            pend     <= '0;
            mask     <= '0;
            CartIReq <= 1'b0;
`ifdef XPORT_HUB_IRQ_LEVEL_EN
            mode     <= '0;
`endif
        end else begin
            // Set is applied after clear so a simultaneous edge is never lost.
            pend     <= (pend & ~pend_clr) | irq_set;
            CartIReq <= |(pend & mask);
            if (commit) begin
                case (Addr)
                    OFS_LEDEN: leden <= DataWr[NUM_LED-1:0];
                    OFS_MASK:  mask  <= DataWr[NUM_IRQ-1:0];
`ifdef XPORT_HUB_IRQ_LEVEL_EN
                    OFS_MODE:  mode  <= DataWr[NUM_IRQ-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < NUM_LED; i++) begin
                duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (commit && is_duty_ofs(Addr, i, NUM_LED)) begin
                    duty[i] <= DataWr[PWM_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            psc <= '0;
            cnt <= '0;
        end else if (psc == PSC_W'(PRESCALE - 1)) begin
            psc <= '0;
            cnt <= cnt + PWM_BITS'(1);
        end else begin
            psc <= psc + PSC_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_LED; g++) begin : g_led
        xport_hub_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .Clk    (Clk),
            .ResetN (ResetN),
            .cnt    (cnt),
            .duty   (duty[g]),
            .enable (leden[g]),
            .led_n  (LedN[g])
        );
    end

    always_comb begin
        DataRd = '0;
        if (En) begin
            case (Addr)
                OFS_LEDEN:   DataRd[NUM_LED-1:0] = leden;
                OFS_PEND:    DataRd[NUM_IRQ-1:0] = pend;
                OFS_MASK:    DataRd[NUM_IRQ-1:0] = mask;
`ifdef XPORT_HUB_IRQ_LEVEL_EN
                OFS_MODE:    DataRd[NUM_IRQ-1:0] = mode;
`endif
                OFS_VERSION: DataRd = VERSION;
                default: begin
                    for (int i = 0; i < NUM_LED; i++) begin
                        if (is_duty_ofs(Addr, i, NUM_LED)) begin
                            DataRd[PWM_BITS-1:0] = duty[i];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_xport_periph_hub.sv
// Bench for xport_periph_hub: register vector table, PWM duty counting, IRQ timing and reset corners.
module tb_xport_periph_hub;
    logic        Clk;
    logic        ResetN;
    logic        En;
    logic [3:0]  Addr;
    logic [15:0] DataWr;
    logic [15:0] DataRd;
    logic        Rd;
    logic        Wr;
    logic [3:0]  IrqIn;
    logic [1:0]  LedN;
    logic        CartIReq;

    xport_periph_hub dut (
        .Clk(Clk), .ResetN(ResetN), .En(En), .Addr(Addr), .DataWr(DataWr),
        .DataRd(DataRd), .Rd(Rd), .Wr(Wr), .IrqIn(IrqIn), .LedN(LedN), .CartIReq(CartIReq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        is_wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       nm;
    } sb_t;

    vec_t tbl [28];
    sb_t  sbq [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected read data is queued when the address is driven, then popped against DataRd.
    task automatic rd(input logic [3:0] a, input logic [15:0] e, input string nm);
        sb_t s;
        sbq.push_back('{exp: e, nm: nm});
        En   = 1'b1;
        Addr = a;
        Rd   = 1'b1;
        #1;
        s  = sbq.pop_front();
        Rd = 1'b0;
        chk(s.nm, DataRd, s.exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [3:0] irq);
        @(posedge Clk); #1;
        En = 1'b1; Addr = a; DataWr = d; Wr = 1'b1;
        IrqIn = IrqIn | irq;
        repeat (3) @(posedge Clk);
        #1;
        Wr = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic pwm_count(output int l0, output int l1);
        l0 = 0; l1 = 0;
        repeat (2) @(posedge Clk);
        for (int i = 0; i < 4096; i++) begin
            @(posedge Clk); #1;
            if (!LedN[0]) l0++;
            if (!LedN[1]) l1++;
        end
    endtask

    task automatic irq_pulse(input int bitn);
        @(posedge Clk); #1;
        IrqIn[bitn] = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        IrqIn[bitn] = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    initial begin
        int l0, l1;
        tbl[0]  = '{1'b0, 4'd0,  16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 4'd1,  16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 4'd2,  16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 4'd15, 16'h0000, 16'h0201};
        tbl[4]  = '{1'b0, 4'd3,  16'h0000, 16'h0000};
        tbl[5]  = '{1'b0, 4'd9,  16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 4'd0,  16'hFFFF, 16'h0000};
        tbl[7]  = '{1'b0, 4'd0,  16'h0000, 16'h0003};
        tbl[8]  = '{1'b1, 4'd2,  16'hFFF7, 16'h0000};
        tbl[9]  = '{1'b0, 4'd2,  16'h0000, 16'h0007};
        tbl[10] = '{1'b1, 4'd4,  16'h1234, 16'h0000};
        tbl[11] = '{1'b0, 4'd4,  16'h0000, 16'h0034};
        tbl[12] = '{1'b1, 4'd5,  16'h00AB, 16'h0000};
        tbl[13] = '{1'b0, 4'd5,  16'h0000, 16'h00AB};
        tbl[14] = '{1'b1, 4'd6,  16'hFFFF, 16'h0000};
        tbl[15] = '{1'b0, 4'd6,  16'h0000, 16'h0000};
        tbl[16] = '{1'b1, 4'd3,  16'hFFFF, 16'h0000};
`ifdef XPORT_HUB_IRQ_LEVEL_EN
        tbl[17] = '{1'b0, 4'd3,  16'h0000, 16'h000F};
`else
        tbl[17] = '{1'b0, 4'd3,  16'h0000, 16'h0000};
`endif
        tbl[18] = '{1'b1, 4'd3,  16'h0000, 16'h0000};
        tbl[19] = '{1'b1, 4'd15, 16'h0000, 16'h0000};
        tbl[20] = '{1'b0, 4'd15, 16'h0000, 16'h0201};
        tbl[21] = '{1'b1, 4'd1,  16'hFFFF, 16'h0000};
        tbl[22] = '{1'b0, 4'd1,  16'h0000, 16'h0000};
        tbl[23] = '{1'b1, 4'd2,  16'h0004, 16'h0000};
        tbl[24] = '{1'b0, 4'd2,  16'h0000, 16'h0004};
        tbl[25] = '{1'b1, 4'd0,  16'h0001, 16'h0000};
        tbl[26] = '{1'b0, 4'd0,  16'h0000, 16'h0001};
        tbl[27] = '{1'b0, 4'd5,  16'h0000, 16'h00AB};

        ResetN = 1'b0; En = 1'b0; Addr = '0; DataWr = '0; Rd = 1'b0; Wr = 1'b0; IrqIn = '0;
        repeat (3) @(posedge Clk);
        #1;
        ResetN = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        chk("reset_ledn", 16'(LedN), 16'h0003);
        chk("reset_irq", 16'(CartIReq), 16'h0000);

        for (int i = 0; i < 28; i++) begin
            if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data, 4'b0000);
            else rd(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d_ofs%0d", i, tbl[i].addr));
        end

        En = 1'b0; Addr = 4'd15; #1;
        chk("rd_en_low", DataRd, 16'h0000);

        // A commit must become visible on the third edge after Wr rises, not earlier.
        @(posedge Clk); #1;
        En = 1'b1; Addr = 4'd2; DataWr = 16'h0003; Wr = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        rd(4'd2, 16'h0004, "mask_before_edge3");
        @(posedge Clk); #1;
        rd(4'd2, 16'h0003, "mask_at_edge3");
        Wr = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        wr(4'd2, 16'h0004, 4'b0000);

        wr(4'd4, 16'h0040, 4'b0000);
        pwm_count(l0, l1);
        chk("pwm_duty40_on", 16'(l0), 16'd1024);
        chk("pwm_led1_disabled", 16'(l1), 16'd0);
        wr(4'd4, 16'h0001, 4'b0000);
        pwm_count(l0, l1);
        chk("pwm_duty01_on", 16'(l0), 16'd16);
        wr(4'd4, 16'h00FF, 4'b0000);
        pwm_count(l0, l1);
        chk("pwm_dutyff_on", 16'(l0), 16'd4096);
        wr(4'd4, 16'h0000, 4'b0000);
        pwm_count(l0, l1);
        chk("pwm_duty00_on", 16'(l0), 16'd0);

        @(posedge Clk); #1;
        IrqIn[2] = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        rd(4'd1, 16'h0004, "pend_after_irq2");
        chk("ireq_not_yet", 16'(CartIReq), 16'h0000);
        IrqIn[2] = 1'b0;
        @(posedge Clk); #1;
        chk("ireq_after_4clk", 16'(CartIReq), 16'h0001);
        irq_pulse(1);
        rd(4'd1, 16'h0006, "pend_irq1_masked");
        chk("ireq_held", 16'(CartIReq), 16'h0001);
        wr(4'd1, 16'h0004, 4'b0000);
        rd(4'd1, 16'h0002, "pend_after_w1c");
        chk("ireq_cleared", 16'(CartIReq), 16'h0000);

        irq_pulse(0);
        rd(4'd1, 16'h0003, "pend_irq0");
        wr(4'd1, 16'h0001, 4'b0001);
        rd(4'd1, 16'h0003, "set_beats_clear");
        IrqIn = '0;
        repeat (4) @(posedge Clk);
        #1;
        wr(4'd1, 16'h0003, 4'b0000);
        rd(4'd1, 16'h0000, "pend_w1c_all");

`ifdef XPORT_HUB_IRQ_LEVEL_EN
        wr(4'd3, 16'h0001, 4'b0000);
        IrqIn[0] = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        wr(4'd1, 16'h0001, 4'b0000);
        rd(4'd1, 16'h0001, "level_w1c_blocked");
        IrqIn = '0;
        repeat (4) @(posedge Clk);
        #1;
        wr(4'd1, 16'h0001, 4'b0000);
        rd(4'd1, 16'h0000, "level_w1c_after_drop");
        wr(4'd3, 16'h0000, 4'b0000);
`endif

        wr(4'd4, 16'h00FF, 4'b0000);
        irq_pulse(2);
        chk("pre_reset_led", 16'(LedN), 16'h0002);
        chk("pre_reset_ireq", 16'(CartIReq), 16'h0001);
        @(posedge Clk); #1;
        En = 1'b1; Addr = 4'd4; DataWr = 16'h0077; Wr = 1'b1;
        @(posedge Clk); #1;
        ResetN = 1'b0;
        #1;
        chk("async_reset_led", 16'(LedN), 16'h0003);
        chk("async_reset_ireq", 16'(CartIReq), 16'h0000);
        repeat (2) @(posedge Clk);
        #1;
        ResetN = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        Wr = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        rd(4'd4, 16'h0000, "no_commit_after_reset");
        rd(4'd1, 16'h0000, "pend_after_reset");
        rd(4'd0, 16'h0000, "leden_after_reset");
        wr(4'd4, 16'h0055, 4'b0000);
        rd(4'd4, 16'h0055, "write_after_reset");

        chk("sb_empty", 16'(sbq.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xport_periph_hub.md
Name: xport_periph_hub

Overview:
Parametrised successor to the primary board-control logic: a Clk-synchronous peripheral hub on the decoded GBA cartridge bus.
- Provides NUM_LED PWM-dimmed, active-low LED channels, replacing on/off LED bits written on the Wr edge.
- Adds an NUM_IRQ-source edge-triggered interrupt controller driving CartIReq, which was previously tied low.
- Sits beside the Cport and BlockRam; its DataRd feeds the top-level read mux.

Parameters:
NUM_LED, 2, number of LED channels (1..8)
PWM_BITS, 8, duty/counter width (4..12)
PRESCALE, 16, Clk cycles per PWM counter step (>=1)
NUM_IRQ, 4, number of interrupt sources (1..16)
VERSION, 16'h0201, value read at offset 15

Ports:
Clk  input  1  system clock
ResetN  input  1  asynchronous active-low reset
En  input  1  block select, already decoded from Addr[23:4]
Addr  input  4  word offset within block
DataWr  input  16  cartridge write data
DataRd  output  16  read data, combinational
Rd  input  1  decoded read strobe, active high
Wr  input  1  decoded write strobe, active high, asynchronous to Clk
IrqIn  input  NUM_IRQ  asynchronous interrupt sources, rising-edge sensitive
LedN  output  NUM_LED  LED drives, active low
CartIReq  output  1  interrupt request to cartridge, active high, registered

Behaviour:
- Reset (ResetN low, async): all registers 0, PWM counter and prescaler 0, LedN all 1, CartIReq 0, sync flops 0.
- Write path:
  - Wr passes through a 2-flop synchroniser; a rising edge of the synchronised Wr with En high commits DataWr to register Addr.
  - The register is visible on the 3rd Clk edge after Wr rises.
  - Writes to undefined offsets are ignored.
  - One commit per Wr pulse.
- Register map (word offsets):
  - 0 LEDEN: bit i enables LED i.
  - 1 PEND: read pending; write-1-to-clear.
  - 2 MASK: IRQ mask.
  - 3 MODE: see Optional Feature.
  - 4..4+NUM_LED-1 DUTY[i]: PWM_BITS LSBs.
  - 15 VERSION.
  - Unused register bits and unused offsets read 0.
- Reads: DataRd = register selected by Addr when En high, else 16'h0000. Rd does not change state.
- PWM:
  - Prescaler counts 0..PRESCALE-1; on wrap, the PWM counter increments, wrapping from all-ones to 0.
  - LED i is on (LedN[i]=0) iff LEDEN[i] and (DUTY[i]==all-ones or cnt < DUTY[i]).
  - DUTY 0 is always off; all-ones is always on.
  - A DUTY write takes effect immediately (no period-boundary shadowing).
  - LedN is registered: one Clk of latency after counter or register change.
- IRQ:
  - IrqIn passes through a 2-flop synchroniser plus a previous-value flop; a synchronised rising edge sets PEND[j].
  - If a set and a W1C clear of the same bit land in the same cycle, set wins.
  - Pending bits set regardless of MASK.
  - CartIReq is registered |(PEND & MASK): asserted one Clk after PEND/MASK update, deasserted one Clk after the last unmasked pending bit clears.
- ResetN asserted mid-write or mid-PWM: immediate return to reset state; a partially synchronised Wr does not commit after release.

Optional Feature:
Macro XPORT_HUB_IRQ_LEVEL_EN.
- Defined: MODE[j]=1 makes source j level-sensitive. PEND[j] is set every cycle the synchronised IrqIn[j] is high, so a W1C clear is ineffective while the input stays high. MODE[j]=0 keeps edge behaviour.
- Undefined: MODE is absent, offset 3 reads 0, writes are ignored, and all sources are edge-triggered.

Decomposition:
- Package xport_hub_pkg: register offset constants (OFS_LEDEN=0, OFS_PEND=1, OFS_MASK=2, OFS_MODE=3, OFS_DUTY0=4, OFS_VERSION=15), data width 16, synchroniser depth 2.
- Sub-module xport_hub_pwm_chan, one per LED: takes cnt, duty, enable; outputs registered LedN bit.
- Prescaler, counter, synchronisers and IRQ logic stay in the top module.

Test Plan:
- Reset, then read offsets 0/1/2/15 -> 0,0,0,16'h0201; LedN=2'b11; CartIReq=0.
- Write LEDEN=1, DUTY0=8'h40, PRESCALE=16 -> LedN[0] low for 64*16 Clk of each 256*16 Clk period; DUTY0=8'hFF -> continuously low; DUTY0=0 -> continuously high.
- Write MASK=4'b0100, pulse IrqIn[2] for 3 Clk -> PEND=4'b0100, CartIReq=1 after 4 Clk. Pulse IrqIn[1] -> PEND=4'b0110. Write PEND=4'b0100 -> CartIReq=0 and PEND=4'b0010.
- Rising edge of IrqIn[0] in the same cycle as a W1C of bit 0 commits -> PEND[0] stays 1.
- Assert ResetN low one Clk after Wr rises for a DUTY write -> after release, DUTY reads 0 and no commit occurs.
- With XPORT_HUB_IRQ_LEVEL_EN, MODE=1, hold IrqIn[0] high and write PEND=1 -> PEND[0] reads 1. Drop IrqIn and write PEND=1 -> reads 0.
